// File: rtl/xmm_write_back_pipe.sv
// xmm_write_back_pipe: converts ALU/memory/FPU write-back results to XMM fixed point
module xmm_write_back_pipe #(
    parameter int XMM_WIDTH = 64,
    parameter int FRAC_BITS = 15,
    parameter int REG_IDX_W = 4,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_src,
    input  logic [REG_IDX_W-1:0] in_idx,
    input  logic [31:0]          alu_res,
    input  logic [31:0]          mem_read_data,
    input  logic [XMM_WIDTH-1:0] fpu_res,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_IDX_W-1:0] out_idx,
    output logic [XMM_WIDTH-1:0] out_data,
    output logic                 out_sat,
    output logic                 out_err,
    input  logic                 sat_clr,
    output logic [15:0]          sat_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [XMM_WIDTH-1:0] MAX_POS = {1'b0, {(XMM_WIDTH-1){1'b1}}};

    logic                 s1_valid;
    logic [2:0]           s1_src;
    logic [REG_IDX_W-1:0] s1_idx;
    logic [31:0]          s1_alu, s1_mem, fp_in;
    logic [XMM_WIDTH-1:0] s1_fpu;
    logic [REG_IDX_W-1:0] q_idx [DEPTH];
    logic [XMM_WIDTH-1:0] q_data [DEPTH];
    logic [DEPTH-1:0]     q_sat, q_err;
    logic [PW-1:0]        wr_ptr, rd_ptr, head;
    logic [PW:0]          count;
    logic                 push, pop, accept;
    logic [XMM_WIDTH-1:0] cv_data;
    logic                 cv_sat, cv_err;
    logic [XMM_WIDTH:0]   fp_res;

    // Returns {sat, data}; value is mant24 * 2^sh with sh = exp - 150 + FRAC_BITS
    function automatic logic [XMM_WIDTH:0] fp_conv(input logic [31:0] f);
        logic [7:0]           e;
        logic [XMM_WIDTH-1:0] mant, mag, res;
        logic                 sat;
        int                   sh;
        e    = f[30:23];
        mant = {{(XMM_WIDTH-24){1'b0}}, 1'b1, f[22:0]};
        sh   = int'(e) - 150 + FRAC_BITS;
        mag  = '0;
        res  = '0;
        sat  = 1'b0;
        if (e == 8'hFF) begin
            sat = 1'b1;
            res = (f[22:0] != '0) ? '0 : (f[31] ? ~MAX_POS : MAX_POS);
        end else if (e != 8'h00) begin
            if (sh >= XMM_WIDTH - 24) begin
                res = f[31] ? ~MAX_POS : MAX_POS;
                sat = !(f[31] && sh == XMM_WIDTH - 24 && f[22:0] == '0);
            end else begin
                mag = (sh >= 0) ? mant << sh : mant >> (-sh);
                res = f[31] ? -mag : mag;
            end
        end
        return {sat, res};
    endfunction

    assign fp_in  = s1_src[2] ? s1_mem : s1_alu;
    assign fp_res = fp_conv(fp_in);

    always_comb begin
        cv_data = '0;
        cv_sat  = 1'b0;
        cv_err  = 1'b0;
        case (s1_src)
            3'b000:         cv_data = {{(XMM_WIDTH-32){1'b0}}, s1_alu} << FRAC_BITS;
            3'b001:         cv_data = {{(XMM_WIDTH-32){s1_alu[31]}}, s1_alu} << FRAC_BITS;
            3'b010, 3'b100: {cv_sat, cv_data} = fp_res;
            3'b110:         cv_data = s1_fpu;
            default:        cv_err = 1'b1;
        endcase
    end

    assign out_valid = count != '0;
    assign pop       = out_valid && out_ready;
    assign push      = s1_valid && (count != FULL || pop);
    assign in_ready  = rst_n && (!s1_valid || push);
    assign accept    = in_valid && in_ready;
    // When empty the head points at the last popped slot so outputs hold
    assign head      = out_valid ? rd_ptr : rd_ptr - 1'b1;
    assign out_idx   = q_idx[head];
    assign out_data  = q_data[head];
    assign out_sat   = q_sat[head];
    assign out_err   = q_err[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_src   <= '0;
            s1_idx   <= '0;
            s1_alu   <= '0;
            s1_mem   <= '0;
            s1_fpu   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_src   <= in_src;
            s1_idx   <= in_idx;
            s1_alu   <= alu_res;
            s1_mem   <= mem_read_data;
            s1_fpu   <= fpu_res;
        end else if (push) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            q_sat  <= '0;
            q_err  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_idx[i]  <= '0;
                q_data[i] <= '0;
            end
        end else begin
            if (push) begin
                q_idx[wr_ptr]  <= s1_idx;
                q_data[wr_ptr] <= cv_data;
                q_sat[wr_ptr]  <= cv_sat;
                q_err[wr_ptr]  <= cv_err;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push != pop)
                count <= push ? count + 1'b1 : count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_count <= '0;
        else if (sat_clr)
            sat_count <= '0;
        else if (pop && out_sat && sat_count != 16'hFFFF)
            sat_count <= sat_count + 1'b1;
    end
endmodule

// File: tb/tb_xmm_write_back_pipe.sv
// tb_xmm_write_back_pipe: table vectors, hand sequences and random traffic against a real-arithmetic model
module tb_xmm_write_back_pipe;
    localparam int F = 15;
    localparam int IW = 4;
    localparam int D = 4;
    localparam int NV = 25;
    localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    typedef struct {
        logic [IW-1:0] idx;
        logic [63:0]   data;
        logic          sat;
        logic          err;
        int            cyc;
    } ent_t;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [63:0] fpu;
        logic [63:0] data;
        logic        sat;
        logic        err;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [2:0]    in_src;
    logic [IW-1:0] in_idx, out_idx;
    logic [31:0]   alu_res, mem_read_data;
    logic [63:0]   fpu_res, out_data;
    logic          out_sat, out_err, sat_clr;
    logic [15:0]   sat_count;

    ent_t        q[$];
    ent_t        tab_ent;
    vec_t        tab[NV];
    bit          use_tab = 0;
    bit          lat_chk = 0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [15:0] exp_sc = '0;

    xmm_write_back_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_src(in_src), .in_idx(in_idx), .alu_res(alu_res),
        .mem_read_data(mem_read_data), .fpu_res(fpu_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_data(out_data), .out_sat(out_sat), .out_err(out_err),
        .sat_clr(sat_clr), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Real-valued fp32 -> fixed conversion, returns {sat, data}
    function automatic logic [64:0] ref_fp(input logic [31:0] f);
        int     e;
        real    mr, mag, qr, lim;
        longint qi;
        e = int'(f[30:23]);
        if (e == 255)
            return (f[22:0] != 23'd0) ? {1'b1, 64'd0} : {1'b1, f[31] ? MINV : MAXV};
        if (e == 0)
            return 65'd0;
        mr  = f[22:0];
        mag = 1.0 + mr / 8388608.0;
        for (int k = 0; k < e - 127 + F; k++) mag = mag * 2.0;
        for (int k = 0; k > e - 127 + F; k--) mag = mag / 2.0;
        lim = 1.0;
        for (int k = 0; k < 63; k++) lim = lim * 2.0;
        if (mag > lim || (mag == lim && !f[31]))
            return {1'b1, f[31] ? MINV : MAXV};
        if (mag == lim)
            return {1'b0, MINV};
        qi = mag;
        qr = qi;
        if (qr > mag) qi = qi - 1;
        return {1'b0, f[31] ? -qi : qi};
    endfunction

    function automatic ent_t ref_ent(input logic [2:0] s, input logic [31:0] a, input logic [31:0] m,
                                     input logic [63:0] fp, input logic [IW-1:0] idx);
        ent_t        e;
        logic [64:0] r;
        longint      sc;
        sc = longint'(1) << F;
        e.idx = idx;
        e.data = '0;
        e.sat = 1'b0;
        e.err = 1'b0;
        e.cyc = 0;
        case (s)
            3'd0: e.data = longint'({32'd0, a}) * sc;
            3'd1: e.data = longint'(signed'(a)) * sc;
            3'd2: begin r = ref_fp(a); e.sat = r[64]; e.data = r[63:0]; end
            3'd4: begin r = ref_fp(m); e.sat = r[64]; e.data = r[63:0]; end
            3'd6: e.data = fp;
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        int         r;
        r = $urandom_range(0, 9);
        e = (r == 0) ? 8'd0 : (r == 1) ? 8'hFF : 8'($urandom_range(100, 192));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // Evaluate handshakes for the current cycle, then advance to the next negedge
    task automatic tick();
        ent_t e, h;
        bit   psat;
        #1;
        check("sat_count", 64'(sat_count), 64'(exp_sc));
        psat = 0;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got idx %h want none", out_idx);
            end else begin
                h = q.pop_front();
                check("pop_idx", 64'(out_idx), 64'(h.idx));
                check("pop_data", out_data, h.data);
                check("pop_sat", 64'(out_sat), 64'(h.sat));
                check("pop_err", 64'(out_err), 64'(h.err));
                if (lat_chk) check("latency", 64'(cyc - h.cyc), 64'd2);
                psat = h.sat;
            end
        end
        exp_sc = sat_clr ? 16'd0 : (psat && exp_sc != 16'hFFFF) ? exp_sc + 16'd1 : exp_sc;
        if (in_valid && in_ready) begin
            e = use_tab ? tab_ent : ref_ent(in_src, alu_res, mem_read_data, fpu_res, in_idx);
            e.cyc = cyc;
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n && q.size() != 0; k++) tick();
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d entries left want 0", q.size());
            q.delete();
        end
    endtask

    task automatic send(input logic [2:0] s, input logic [31:0] a, input logic [31:0] m,
                        input logic [63:0] fp, input logic [IW-1:0] idx);
        in_src = s;
        alu_res = a;
        mem_read_data = m;
        fpu_res = fp;
        in_idx = idx;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        drain(8);
    endtask

    initial begin
        tab[0]  = '{3'b010, 32'h3F80_0000, 32'h0, 64'h0, 64'h0000_0000_0000_8000, 1'b0, 1'b0};
        tab[1]  = '{3'b001, 32'hFFFF_FFFF, 32'h0, 64'h0, 64'hFFFF_FFFF_FFFF_8000, 1'b0, 1'b0};
        tab[2]  = '{3'b000, 32'hFFFF_FFFF, 32'h0, 64'h0, 64'h0000_7FFF_FFFF_8000, 1'b0, 1'b0};
        tab[3]  = '{3'b100, 32'h1234_5678, 32'h7F80_0000, 64'h0, MAXV, 1'b1, 1'b0};
        tab[4]  = '{3'b100, 32'h3F80_0000, 32'h7FC0_0000, 64'h0, 64'h0, 1'b1, 1'b0};
        tab[5]  = '{3'b011, 32'h3F80_0000, 32'h3F80_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1};
        tab[6]  = '{3'b110, 32'h3F80_0000, 32'h0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0};
        tab[7]  = '{3'b010, 32'hBF80_0000, 32'h0, 64'h0, 64'hFFFF_FFFF_FFFF_8000, 1'b0, 1'b0};
        tab[8]  = '{3'b010, 32'h3F00_0000, 32'h0, 64'h0, 64'h0000_0000_0000_4000, 1'b0, 1'b0};
        tab[9]  = '{3'b010, 32'h0000_0001, 32'h0, 64'h0, 64'h0, 1'b0, 1'b0};
        tab[10] = '{3'b010, 32'h8000_0000, 32'h0, 64'h0, 64'h0, 1'b0, 1'b0};
        tab[11] = '{3'b010, 32'hFF80_0000, 32'h0, 64'h0, MINV, 1'b1, 1'b0};
        tab[12] = '{3'b010, 32'h3380_0000, 32'h0, 64'h0, 64'h0, 1'b0, 1'b0};
        tab[13] = '{3'b010, 32'h5780_0000, 32'h0, 64'h0, MAXV, 1'b1, 1'b0};
        tab[14] = '{3'b010, 32'hD780_0000, 32'h0, 64'h0, MINV, 1'b0, 1'b0};
        tab[15] = '{3'b010, 32'h5700_0000, 32'h0, 64'h0, 64'h4000_0000_0000_0000, 1'b0, 1'b0};
        tab[16] = '{3'b100, 32'h7F80_0000, 32'h3F80_0000, 64'h0, 64'h0000_0000_0000_8000, 1'b0, 1'b0};
        tab[17] = '{3'b111, 32'h3F80_0000, 32'h0, 64'h5555_5555_5555_5555, 64'h0, 1'b0, 1'b1};
        tab[18] = '{3'b101, 32'h3F80_0000, 32'h3F80_0000, 64'h0, 64'h0, 1'b0, 1'b1};
        tab[19] = '{3'b010, 32'hBFC0_0000, 32'h0, 64'h0, 64'hFFFF_FFFF_FFFF_4000, 1'b0, 1'b0};
        tab[20] = '{3'b010, 32'h3F80_0001, 32'h0, 64'h0, 64'h0000_0000_0000_8000, 1'b0, 1'b0};
        tab[21] = '{3'b010, 32'hBF80_0001, 32'h0, 64'h0, 64'hFFFF_FFFF_FFFF_8000, 1'b0, 1'b0};
        tab[22] = '{3'b001, 32'h8000_0000, 32'h0, 64'h0, 64'hFFFF_C000_0000_0000, 1'b0, 1'b0};
        tab[23] = '{3'b010, 32'h7F80_0001, 32'h0, 64'h0, 64'h0, 1'b1, 1'b0};
        tab[24] = '{3'b010, 32'h5F00_0000, 32'h0, 64'h0, MAXV, 1'b1, 1'b0};

        in_valid = 1'b0;
        in_src = '0;
        in_idx = '0;
        alu_res = '0;
        mem_read_data = '0;
        fpu_res = '0;
        out_ready = 1'b1;
        sat_clr = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_idx", 64'(out_idx), 64'd0);
        check("rst_flags", 64'({out_sat, out_err}), 64'd0);
        check("rst_sat_count", 64'(sat_count), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("in_ready_release", 64'(in_ready), 64'd1);

        lat_chk = 1;
        for (int i = 0; i < NV; i++) begin
            tab_ent = '{idx: IW'(i), data: tab[i].data, sat: tab[i].sat, err: tab[i].err, cyc: 0};
            use_tab = 1;
            in_src = tab[i].src;
            alu_res = tab[i].alu;
            mem_read_data = tab[i].mem;
            fpu_res = tab[i].fpu;
            in_idx = IW'(i);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            use_tab = 0;
            drain(6);
        end
        lat_chk = 0;

        // sustained one-per-cycle streaming
        for (int k = 0; k < 12; k++) begin
            in_src = 3'($urandom_range(0, 2));
            alu_res = (in_src == 3'd2) ? rand_fp() : $urandom;
            in_idx = IW'(k);
            in_valid = 1'b1;
            #1;
            check("stream_in_ready", 64'(in_ready), 64'd1);
            if (k >= 2) check("stream_out_valid", 64'(out_valid), 64'd1);
            tick();
        end
        in_valid = 1'b0;
        drain(8);

        // fill FIFO plus S1 with out_ready low, then pop and push together
        out_ready = 1'b0;
        for (int i = 0; i <= D; i++) begin
            in_src = 3'd0;
            alu_res = $urandom;
            in_idx = IW'(i);
            in_valid = 1'b1;
            #1 check("fill_in_ready", 64'(in_ready), 64'd1);
            tick();
        end
        in_idx = IW'(D + 1);
        for (int k = 0; k < 2; k++) begin
            #1;
            check("full_in_ready", 64'(in_ready), 64'd0);
            check("full_out_valid", 64'(out_valid), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        #1 check("full_pop_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        drain(20);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_src = 3'($urandom);
            alu_res = (in_src == 3'd2 || $urandom_range(0, 1) == 0) ? rand_fp() : $urandom;
            mem_read_data = rand_fp();
            fpu_res = {$urandom, $urandom};
            in_idx = IW'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            sat_clr = ($urandom_range(0, 31) == 0);
            tick();
        end
        in_valid = 1'b0;
        sat_clr = 1'b0;
        out_ready = 1'b1;
        drain(20);

        // sat_count after inf then NaN from memory
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        send(3'b100, 32'h0, 32'h7F80_0000, 64'h0, 4'd1);
        send(3'b100, 32'h0, 32'h7FC0_0000, 64'h0, 4'd2);
        check("sat_count_two", 64'(sat_count), 64'd2);

        // reset with three queued entries
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_src = 3'b100;
            mem_read_data = 32'hFF80_0000;
            in_idx = IW'(i + 7);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("queued_three", 64'(q.size()), 64'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_sat_count", 64'(sat_count), 64'd0);
        check("mid_rst_out_data", out_data, 64'd0);
        check("mid_rst_idx_flags", 64'({out_idx, out_sat, out_err}), 64'd0);
        q.delete();
        exp_sc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_in_ready", 64'(in_ready), 64'd1);
        check("release_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("no_stale_valid", 64'(out_valid), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
